// File: rtl/axi4_lite_regfile.sv
// rtl/axi4_lite_regfile.sv - AXI4-Lite register file; byte-strobe writes enabled by AXI4L_REGFILE_WSTRB_EN
module axi4_lite_regfile #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned           STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned           LANE_BITS   = $clog2(STRB_WIDTH);
    localparam int unsigned           IDX_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A  = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    // Register index of an address: byte-lane bits are dropped after rebasing.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> LANE_BITS;
    endfunction

    // An address hits only at or above the base and inside the register window.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && (word_index(a) < NUM_REGS_A);
    endfunction

`ifdef AXI4L_REGFILE_WSTRB_EN
    // Only strobed byte lanes take the new data.
    function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [STRB_WIDTH-1:0] strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(STRB_WIDTH); k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_word[k*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    // Register storage and AXI-facing state
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_full;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_WIDTH-1:0] r_w_strb;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [NUM_REGS-1:0]   r_wr_pulse;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    // Write-path combinational terms
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_avail;
    logic                  w_w_avail;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0] w_wr_strb;
    logic                  w_b_free;
    logic                  w_commit;
    logic                  w_wr_hit;
    logic [IDX_WIDTH-1:0]  w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_wr_word;
    logic                  w_aw_full_nxt;
    logic                  w_w_full_nxt;
    logic [NUM_REGS-1:0]   w_reg_we;

    // Read-path combinational terms
    logic                  w_ar_hs;
    logic                  w_rd_hit;
    logic [IDX_WIDTH-1:0]  w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_rd_word_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rvalid_nxt;

    assign w_aw_hs    = awvalid && r_awready;
    assign w_w_hs     = wvalid && r_wready;
    assign w_aw_avail = r_aw_full || w_aw_hs;
    assign w_w_avail  = r_w_full || w_w_hs;
    assign w_wr_addr  = r_aw_full ? r_aw_addr : awaddr;
    assign w_wr_data  = r_w_full ? r_w_data : wdata;
    assign w_wr_strb  = r_w_full ? r_w_strb : wstrb;

    // A new response may be produced in the cycle the old one is being taken.
    assign w_b_free   = !r_bvalid || bready;
    assign w_commit   = w_aw_avail && w_w_avail && w_b_free;

    assign w_wr_hit   = addr_hit(w_wr_addr);
    assign w_wr_word  = word_index(w_wr_addr);
    assign w_wr_idx   = w_wr_word[IDX_WIDTH-1:0];

    assign w_aw_full_nxt = w_aw_avail && !w_commit;
    assign w_w_full_nxt  = w_w_avail && !w_commit;

`ifndef AXI4L_REGFILE_WSTRB_EN
    logic w_unused_strb;
    assign w_unused_strb = ^w_wr_strb;
`endif

    // One-hot write enable for the committed register (none on a miss)
    always_comb begin
        w_reg_we = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            w_reg_we[i] = w_commit && w_wr_hit && (w_wr_idx == IDX_WIDTH'(i));
        end
    end

    // AW and W holds fill independently and empty together on commit
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= !w_aw_full_nxt;
            r_wready  <= !w_w_full_nxt;
            if (w_aw_hs) begin
                r_aw_addr <= awaddr;
            end
            if (w_w_hs) begin
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
        end
    end

    // Write response: set by a commit, held until bready
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register contents and the per-register written pulse
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_reg_we;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_reg_we[i]) begin
`ifdef AXI4L_REGFILE_WSTRB_EN
                    r_regs[i] <= merge_word(r_regs[i], w_wr_data, w_wr_strb);
`else
                    r_regs[i] <= w_wr_data;
`endif
                end
            end
        end
    end

    assign w_ar_hs       = arvalid && r_arready;
    assign w_rd_hit      = addr_hit(araddr);
    assign w_rd_word_idx = word_index(araddr);
    assign w_rd_idx      = w_rd_word_idx[IDX_WIDTH-1:0];
    assign w_rvalid_nxt  = w_ar_hs ? 1'b1 : ((r_rvalid && rready) ? 1'b0 : r_rvalid);

    // Read mux over current register values (pre-commit on a same-edge write)
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_rd_idx == IDX_WIDTH'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Read channel: one outstanding response, arready is the inverse of rvalid
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_hit ? w_rd_word : '0;
                r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Flatten register array onto the fabric-facing bus
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign arready  = r_arready;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign wr_pulse = r_wr_pulse;

endmodule
